// File: rtl/top.sv
// ---------------------------------------------------------------------------
// top -- single-cycle RV32I integer / control-flow execution core.
//
// Every cycle the word on `inst` is executed as the instruction at `pc`.
// The register write and the PC update commit together on the rising clock
// edge. Loads, stores, FENCE, SYSTEM and M-extension words are not executed.
// They are flagged as illegal and simply fall through to pc+4.
//
// Ports
//   clk       in   1   clock, all state updates on the rising edge
//   reset_x   in   1   asynchronous active-high reset (pc=RESET_PC, regs=0)
//   inst      in   32  instruction at the current pc, valid every cycle
//   pc        out  32  current pc (registered)
//   rd_we     out  1   current instruction commits a register write
//   rd_addr   out  5   destination register field of the current instruction
//   rd_data   out  32  writeback value of the current instruction
//   illegal   out  1   current instruction is unsupported/undecodable
//   misalign  out  1   taken jump/branch target is not word aligned
// ---------------------------------------------------------------------------
module top #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic [31:0] inst,
  output logic [31:0] pc,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        illegal,
  output logic        misalign
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Decoded view of the current instruction.
  typedef struct packed {
    logic        legal;   // opcode/funct combination is supported
    logic        wb;      // instruction class writes rd
    logic        xfer;    // control transfer is taken this cycle
    logic [31:0] target;  // transfer target (meaningful only when xfer)
    logic [31:0] result;  // writeback value
  } dec_t;

  // -------------------------------------------------------------------------
  // Instruction fields and immediates
  // -------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_u, imm_j, imm_b;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

  // -------------------------------------------------------------------------
  // Register file: x0 is never written, so it always reads back as zero.
  // Reads are combinational and see the pre-edge value, which gives
  // read-before-write semantics when rd matches rs1/rs2.
  // -------------------------------------------------------------------------
  logic [31:0] rf [32];
  logic [31:0] rs1_val, rs2_val;

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  // -------------------------------------------------------------------------
  // Shared integer ALU for OP and OP-IMM. `alt` selects SUB / SRA.
  // -------------------------------------------------------------------------
  function automatic logic [31:0] alu(input logic [2:0]  f3,
                                      input logic        alt,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (f3)
      3'd0: r = alt ? (a - b) : (a + b);
      3'd1: r = a << b[4:0];
      3'd2: r = {31'd0, $signed(a) < $signed(b)};
      3'd3: r = {31'd0, a < b};
      3'd4: r = a ^ b;
      3'd5: r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6: r = a | b;
      3'd7: r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Branch condition; funct3 010/011 are rejected by the decoder.
  function automatic logic br_cond(input logic [2:0]  f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    logic c;
    c = 1'b0;
    case (f3)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = $signed(a) <  $signed(b);
      3'd5: c = $signed(a) >= $signed(b);
      3'd6: c = a <  b;
      3'd7: c = a >= b;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // -------------------------------------------------------------------------
  // Decode / execute
  // -------------------------------------------------------------------------
  logic [31:0] pc_plus4;
  dec_t        dec;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    dec        = '0;
    dec.target = pc_plus4;
    case (opcode)
      OPC_LUI: begin
        dec.legal  = 1'b1;
        dec.wb     = 1'b1;
        dec.result = imm_u;
      end
      OPC_AUIPC: begin
        dec.legal  = 1'b1;
        dec.wb     = 1'b1;
        dec.result = pc + imm_u;
      end
      OPC_JAL: begin
        dec.legal  = 1'b1;
        dec.wb     = 1'b1;
        dec.xfer   = 1'b1;
        dec.target = pc + imm_j;
        dec.result = pc_plus4;
      end
      OPC_JALR: begin
        dec.legal  = (funct3 == 3'd0);
        dec.wb     = 1'b1;
        dec.xfer   = 1'b1;
        // Bit 0 is cleared before the alignment check, so only bit 1 can
        // make a JALR target misaligned.
        dec.target = (rs1_val + imm_i) & ~32'd1;
        dec.result = pc_plus4;
      end
      OPC_BRANCH: begin
        dec.legal  = (funct3 != 3'd2) && (funct3 != 3'd3);
        dec.xfer   = br_cond(funct3, rs1_val, rs2_val);
        dec.target = pc + imm_b;
      end
      OPC_OPIMM: begin
        // Shift-immediates carry a funct7-like field in imm[11:5]; only SRAI
        // may use the alternate encoding.
        case (funct3)
          3'd1:    dec.legal = (funct7 == F7_BASE);
          3'd5:    dec.legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: dec.legal = 1'b1;
        endcase
        dec.wb     = 1'b1;
        dec.result = alu(funct3, (funct3 == 3'd5) && inst[30], rs1_val, imm_i);
      end
      OPC_OP: begin
        dec.legal  = (funct7 == F7_BASE) ||
                     ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
        dec.wb     = 1'b1;
        dec.result = alu(funct3, inst[30], rs1_val, rs2_val);
      end
      default: dec = '{legal: 1'b0, wb: 1'b0, xfer: 1'b0,
                       target: pc_plus4, result: 32'd0};
    endcase
  end

  // Illegal takes priority: a misaligned flag is only raised for a legal,
  // taken transfer.
  logic [31:0] next_pc;
  logic        take;

  assign illegal  = ~dec.legal;
  assign misalign = dec.legal & dec.xfer & (dec.target[1:0] != 2'b00);
  assign take     = dec.legal & dec.xfer & ~misalign;
  assign next_pc  = take ? dec.target : pc_plus4;

  assign rd_addr  = rd;
  assign rd_data  = dec.result;
  assign rd_we    = dec.legal & dec.wb & ~misalign & (rd != 5'd0);

  // -------------------------------------------------------------------------
  // State: an edge while reset is held discards the pending instruction.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset_x) begin
    if (reset_x) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc <= next_pc;
      if (rd_we) rf[rd] <= rd_data;
    end
  end

endmodule

// File: tb/tb_top.sv
// ---------------------------------------------------------------------------
// tb_top -- directed-vector bench for the single-cycle RV32I core `top`.
// Each vector drives one instruction, checks the combinational writeback /
// flag outputs a little after the falling edge, lets one rising edge commit,
// then checks the resulting pc. Register contents are observed through the
// rd_data of later instructions that read them.
// ---------------------------------------------------------------------------
module tb_top;

  logic        clk;
  logic        reset_x;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        illegal;
  logic        misalign;

  int checks;
  int failures;

  top #(.RESET_PC(32'h0000_0000)) dut (
    .clk      (clk),
    .reset_x  (reset_x),
    .inst     (inst),
    .pc       (pc),
    .rd_we    (rd_we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .illegal  (illegal),
    .misalign (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one instruction (called at a falling edge), check its decode,
  // let the next rising edge commit, and check pc at the following fall.
  task automatic step(input string tag, input logic [31:0] i,
                      input logic we, input logic [31:0] data,
                      input logic ill, input logic mis, input logic [31:0] npc);
    inst = i;
    #1;
    chk({tag, ".rd_we"}, 32'(rd_we), 32'(we));
    chk({tag, ".illegal"}, 32'(illegal), 32'(ill));
    chk({tag, ".misalign"}, 32'(misalign), 32'(mis));
    if (we) begin
      chk({tag, ".rd_addr"}, 32'(rd_addr), 32'(i[11:7]));
      chk({tag, ".rd_data"}, rd_data, data);
    end
    @(negedge clk);
    chk({tag, ".pc"}, pc, npc);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with JAL x0,+2: misaligned target, no write, falls through.
    reset_x = 1'b1;
    inst    = 32'h0020_006F;
    #1;
    chk("rst.pc", pc, 32'h0);
    chk("rst.misalign", 32'(misalign), 32'd1);
    chk("rst.rd_we", 32'(rd_we), 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    chk("rst.pc_held", pc, 32'h0);
    reset_x = 1'b0;
    @(negedge clk);
    chk("jal_mis.pc", pc, 32'h4);

    // Reset, then JAL x1,+8.
    reset_x = 1'b1;
    inst    = 32'h0080_00EF;
    #1;
    chk("rst2.pc", pc, 32'h0);
    chk("jal.rd_we", 32'(rd_we), 32'd1);
    chk("jal.rd_addr", 32'(rd_addr), 32'd1);
    chk("jal.rd_data", rd_data, 32'h4);
    chk("jal.misalign", 32'(misalign), 32'd0);
    reset_x = 1'b0;
    @(negedge clk);
    chk("jal.pc", pc, 32'h8);

    // ADD x6,x1,x0 exposes x1; then reset mid-cycle.
    inst = 32'h0000_8333;
    #1;
    chk("x1_read", rd_data, 32'h4);
    reset_x = 1'b1;
    #1;
    chk("mid_rst.pc", pc, 32'h0);
    chk("mid_rst.x1", rd_data, 32'h0);
    @(negedge clk);
    chk("mid_rst.pc_held", pc, 32'h0);
    reset_x = 1'b0;

    // Main directed stream starting at pc 0.
    step("addi_m1",  32'hFFF0_0293, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0014 - 32'h10);
    step("bltu",     32'h0050_6863, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0014);
    step("bgeu_nt",  32'h0050_7863, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0018);
    step("blt_nt",   32'h0050_4863, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_001C);
    step("bge_t",    32'h0050_5863, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_002C);
    step("addi_103", 32'h1030_0293, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'h0000_0030);
    step("jalr_mis", 32'h0002_8067, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0034);
    step("jalr_ok",  32'h0012_80E7, 1'b1, 32'h0000_0038, 1'b0, 1'b0, 32'h0000_0104);
    step("lw_ill",   32'h0000_2003, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0108);
    step("addi_x0",  32'h0050_0013, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_010C);
    step("sub",      32'h4050_0333, 1'b1, 32'hFFFF_FEFD, 1'b0, 1'b0, 32'h0000_0110);
    step("srai",     32'h4043_5393, 1'b1, 32'hFFFF_FFEF, 1'b0, 1'b0, 32'h0000_0114);
    step("srli",     32'h0043_5393, 1'b1, 32'h0FFF_FFEF, 1'b0, 1'b0, 32'h0000_0118);
    step("slt",      32'h0053_2433, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_011C);
    step("sltu",     32'h0053_3433, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0120);
    step("mul_ill",  32'h0200_0033, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0124);
    step("f7_ill",   32'h4000_4033, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0128);
    step("x0_read",  32'h0000_04B3, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_012C);
    step("jalr_neg", 32'hFFC0_0067, 1'b0, 32'h0,         1'b0, 1'b0, 32'hFFFF_FFFC);
    step("jal_wrap", 32'h0080_00EF, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0004);
    step("rbw",      32'h0012_8293, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0000_0008);
    step("x5_read",  32'h0002_8533, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0000_000C);
    step("beq_mis",  32'h0000_0163, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0010);
    step("bne_nt",   32'h0000_1163, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0014);
    step("lui",      32'hABCD_E0B7, 1'b1, 32'hABCD_E000, 1'b0, 1'b0, 32'h0000_0018);
    step("auipc",    32'h0000_1117, 1'b1, 32'h0000_1018, 1'b0, 1'b0, 32'h0000_001C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
